// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU constants, pipeline control struct and parameter
//                legality check for cla_pipe_addsub.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int CLA_GROUP = 4;

    // Per-stage control payload; the data payload is width-dependent and is
    // declared next to the stage that owns it.
    typedef struct packed {
        logic valid;
        logic carry;
`ifdef CLA_PIPE_SAT_EN
        logic sat;
`endif
    } stage_ctl_t;

    function automatic bit cla_cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= 4) && (width > 0) &&
               ((width % (CLA_GROUP * stages)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_pipe_addsub_if.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_addsub_if
//  Description : Operand/result valid-ready bundle for cla_pipe_addsub.
//  Revision    : 1.0  initial release
// ============================================================================
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
`ifdef CLA_PIPE_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
`ifdef CLA_PIPE_SAT_EN
        output sat,
`endif
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
`ifdef CLA_PIPE_SAT_EN
        input  sat,
`endif
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface
`default_nettype wire

// File: rtl/cla_group4.sv
`default_nettype none
// ============================================================================
//  Module      : cla_group4
//  Description : 4-bit carry-lookahead group: sum plus group generate/propagate.
//  Revision    : 1.0  initial release
// ============================================================================
module cla_group4 (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    input  wire logic       cin,
    output logic      [3:0] sum,
    output logic            g,
    output logic            p
);
    logic [3:0] w_gi;
    logic [3:0] w_pi;
    logic [3:0] w_c;

    assign w_gi = a & b;
    assign w_pi = a ^ b;

    assign w_c[0] = cin;
    assign w_c[1] = w_gi[0] | (w_pi[0] & cin);
    assign w_c[2] = w_gi[1] | (w_pi[1] & w_gi[0]) | (&w_pi[1:0] & cin);
    assign w_c[3] = w_gi[2] | (w_pi[2] & w_gi[1]) | (&w_pi[2:1] & w_gi[0]) |
                    (&w_pi[2:0] & cin);

    assign sum = w_pi ^ w_c;
    assign g   = w_gi[3] | (w_pi[3] & w_gi[2]) | (&w_pi[3:2] & w_gi[1]) |
                 (&w_pi[3:1] & w_gi[0]);
    assign p   = &w_pi;

endmodule
`default_nettype wire

// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_addsub
//  Description : Pipelined carry-lookahead add/sub, one WIDTH/STAGES slice per
//                register stage, global-stall valid/ready flow control.
//                Optional saturation enabled by defining CLA_PIPE_SAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module cla_pipe_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    cla_pipe_addsub_if.slave bus
);
    localparam int SLICE_W = WIDTH / STAGES;
    localparam int NGRP    = SLICE_W / CLA_GROUP;

    logic             adv;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;
    logic             r_out_ovf;
    logic             r_out_zero;

    if (!cla_cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("cla_pipe_addsub: WIDTH must be a multiple of 4*STAGES, STAGES 1..4");
    end

    // Whole pipe advances together; the output register is the only stall source.
    assign adv           = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_out_sum;
    assign bus.cout      = r_out_cout;
    assign bus.ovf       = r_out_ovf;
    assign bus.zero      = r_out_zero;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SLICE_W;
        localparam int HI = WIDTH - LO - SLICE_W;

        logic [SLICE_W-1:0] w_a;
        logic [SLICE_W-1:0] w_b;
        logic [SLICE_W-1:0] w_s;
        logic               w_cin;
        logic               w_vld;
`ifdef CLA_PIPE_SAT_EN
        logic               w_sat;
`endif
        logic [NGRP-1:0]    w_g;
        logic [NGRP-1:0]    w_p;
        logic [NGRP:0]      w_c;

        if (k == 0) begin : g_src
            assign w_a   = bus.a[SLICE_W-1:0];
            assign w_b   = bus.b[SLICE_W-1:0] ^ {SLICE_W{bus.sub}};
            assign w_cin = bus.sub;
            assign w_vld = bus.in_valid;
`ifdef CLA_PIPE_SAT_EN
            assign w_sat = bus.sat;
`endif
        end else begin : g_src
            assign w_a   = g_stage[k-1].g_reg.r_ua[SLICE_W-1:0];
            assign w_b   = g_stage[k-1].g_reg.r_ub[SLICE_W-1:0];
            assign w_cin = g_stage[k-1].g_reg.r_ctl.carry;
            assign w_vld = g_stage[k-1].g_reg.r_ctl.valid;
`ifdef CLA_PIPE_SAT_EN
            assign w_sat = g_stage[k-1].g_reg.r_ctl.sat;
`endif
        end

        for (genvar j = 0; j < NGRP; j++) begin : g_grp
            cla_group4 u_grp (
                .a   (w_a[CLA_GROUP*j +: CLA_GROUP]),
                .b   (w_b[CLA_GROUP*j +: CLA_GROUP]),
                .cin (w_c[j]),
                .sum (w_s[CLA_GROUP*j +: CLA_GROUP]),
                .g   (w_g[j]),
                .p   (w_p[j])
            );
        end

        // Group-level lookahead across the slice; unrolled into two-level logic.
        always_comb begin
            logic carry;
            carry  = w_cin;
            w_c[0] = carry;
            for (int j = 0; j < NGRP; j++) begin
                carry    = w_g[j] | (w_p[j] & carry);
                w_c[j+1] = carry;
            end
        end

        if (k < STAGES - 1) begin : g_reg
            logic [LO+SLICE_W-1:0] r_sum;
            logic [HI-1:0]         r_ua;
            logic [HI-1:0]         r_ub;
            stage_ctl_t            r_ctl;
            logic [LO+SLICE_W-1:0] w_sum_nxt;
            logic [HI-1:0]         w_ua_nxt;
            logic [HI-1:0]         w_ub_nxt;

            if (k == 0) begin : g_nxt
                assign w_sum_nxt = w_s;
                assign w_ua_nxt  = bus.a[WIDTH-1:SLICE_W];
                assign w_ub_nxt  = bus.b[WIDTH-1:SLICE_W] ^ {HI{bus.sub}};
            end else begin : g_nxt
                assign w_sum_nxt = {w_s, g_stage[k-1].g_reg.r_sum};
                assign w_ua_nxt  = g_stage[k-1].g_reg.r_ua[HI+SLICE_W-1:SLICE_W];
                assign w_ub_nxt  = g_stage[k-1].g_reg.r_ub[HI+SLICE_W-1:SLICE_W];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sum <= '0;
                    r_ua  <= '0;
                    r_ub  <= '0;
                    r_ctl <= '0;
                end else if (adv) begin
                    r_sum       <= w_sum_nxt;
                    r_ua        <= w_ua_nxt;
                    r_ub        <= w_ub_nxt;
                    r_ctl.valid <= w_vld;
                    r_ctl.carry <= w_c[NGRP];
`ifdef CLA_PIPE_SAT_EN
                    r_ctl.sat   <= w_sat;
`endif
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] w_raw;
            logic [WIDTH-1:0] w_fin;
            logic             w_ovf;

            if (k == 0) begin : g_asm
                assign w_raw = w_s;
            end else begin : g_asm
                assign w_raw = {w_s, g_stage[k-1].g_reg.r_sum};
            end

            assign w_ovf = (w_a[SLICE_W-1] == w_b[SLICE_W-1]) &&
                           (w_s[SLICE_W-1] != w_a[SLICE_W-1]);

`ifdef CLA_PIPE_SAT_EN
            always_comb begin
                w_fin = w_raw;
                if (w_sat && w_ovf)
                    w_fin = w_a[SLICE_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
            end
`else
            assign w_fin = w_raw;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_out_sum   <= '0;
                    r_out_cout  <= 1'b0;
                    r_out_ovf   <= 1'b0;
                    r_out_zero  <= 1'b0;
                end else if (adv) begin
                    r_out_valid <= w_vld;
                    r_out_sum   <= w_vld ? w_fin : '0;
                    r_out_cout  <= w_vld && w_c[NGRP];
                    r_out_ovf   <= w_vld && w_ovf;
                    r_out_zero  <= w_vld && (w_fin == '0);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_addsub
//  Description : Self-checking bench for cla_pipe_addsub (16/2 and 32/4 builds).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cla_pipe_addsub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(16)) bus16 ();
    cla_pipe_addsub_if #(.WIDTH(32)) bus32 ();

    cla_pipe_addsub #(.WIDTH(16), .STAGES(2)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    cla_pipe_addsub #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc_cyc;
    } exp_t;

    exp_t        q [2][$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          lat_chk = 0;
    int          lat_exp [2] = '{2, 4};
    int          n_out [2] = '{0, 0};
    int          n_acc [2] = '{0, 0};
    bit          prev_hold [2] = '{0, 0};
    logic [31:0] prev_sum [2];
    logic [31:0] last_sum;
    logic        last_cout, last_ovf, last_zero;
    logic        obs_ov, obs_ir;
    logic [31:0] obs_sum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the operand values.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input bit sub, input bit sat);
        exp_t   e;
        longint m, ua, ub, sa, sb, r;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        r  = sub ? sa - sb : sa + sb;
        e.ovf  = (r >= m / 2) || (r < -(m / 2));
        e.cout = sub ? (ua >= ub) : ((ua + ub) >= m);
        e.sum  = 32'(r & (m - 1));
        if (sat && e.ovf) e.sum = (sa >= 0) ? 32'(m / 2 - 1) : 32'(m / 2);
        e.zero = (e.sum == 0);
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic beat(input int sel, input bit iv, input logic [31:0] a, input logic [31:0] b,
                        input bit sub, input bit sat, input bit ordy);
        logic        ov, ir, oc, oo, oz;
        logic [31:0] os;
        exp_t        e;
        int          w;
        w = (sel != 0) ? 32 : 16;
        @(negedge clk);
        bus16.in_valid = (sel == 0) && iv;  bus16.out_ready = (sel == 0) ? ordy : 1'b1;
        bus32.in_valid = (sel == 1) && iv;  bus32.out_ready = (sel == 1) ? ordy : 1'b1;
        bus16.a = a[15:0];  bus16.b = b[15:0];  bus16.sub = sub;
        bus32.a = a;        bus32.b = b;        bus32.sub = sub;
`ifdef CLA_PIPE_SAT_EN
        bus16.sat = sat;    bus32.sat = sat;
`endif
        #1;
        if (sel == 0) begin
            ov = bus16.out_valid; ir = bus16.in_ready; os = {16'h0, bus16.sum};
            oc = bus16.cout; oo = bus16.ovf; oz = bus16.zero;
        end else begin
            ov = bus32.out_valid; ir = bus32.in_ready; os = bus32.sum;
            oc = bus32.cout; oo = bus32.ovf; oz = bus32.zero;
        end
        obs_ov = ov; obs_ir = ir; obs_sum = os;
        cyc++;
        if (rst) begin
            prev_hold[sel] = 1'b0;
            return;
        end
        if (prev_hold[sel]) chk("hold_sum", os, prev_sum[sel]);
        chk("in_ready", {31'h0, ir}, {31'h0, (!ov || ordy)});
        if (!ov) begin
            chk("idle_sum", os, 32'h0);
            chk("idle_flags", {29'h0, oc, oo, oz}, 32'h0);
        end
        if (ov && ordy) begin
            if (q[sel].size() == 0) begin
                chk("spurious_out", {31'h0, ov}, 32'h0);
            end else begin
                e = q[sel].pop_front();
                chk("sum", os, e.sum);
                chk("cout", {31'h0, oc}, {31'h0, e.cout});
                chk("ovf", {31'h0, oo}, {31'h0, e.ovf});
                chk("zero", {31'h0, oz}, {31'h0, e.zero});
                if (lat_chk) chk("latency", cyc - e.acc_cyc, lat_exp[sel]);
                last_sum = os; last_cout = oc; last_ovf = oo; last_zero = oz;
                n_out[sel]++;
            end
        end
        prev_hold[sel] = ov && !ordy;
        prev_sum[sel]  = os;
        if (iv && ir) begin
            e = model(w, a, b, sub, sat);
            e.acc_cyc = cyc;
            q[sel].push_back(e);
            n_acc[sel]++;
        end
    endtask

    task automatic drain(input int sel);
        int n;
        n = 0;
        while (q[sel].size() != 0 && n < 50) begin
            beat(sel, 0, 32'h0, 32'h0, 0, 0, 1);
            n++;
        end
        chk("drain_empty", q[sel].size(), 32'h0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rs, rsat, riv, rordy;
        int          sent, base;

        rst = 1'b1;
        bus16.in_valid = 0; bus16.out_ready = 1; bus16.a = 0; bus16.b = 0; bus16.sub = 0;
        bus32.in_valid = 0; bus32.out_ready = 1; bus32.a = 0; bus32.b = 0; bus32.sub = 0;
`ifdef CLA_PIPE_SAT_EN
        bus16.sat = 0; bus32.sat = 0;
`endif
        repeat (3) beat(0, 0, 32'h0, 32'h0, 0, 0, 1);
        rst = 1'b0;

        // Reset state, both builds
        beat(0, 0, 32'h0, 32'h0, 0, 0, 1);
        chk("reset_out_valid16", {31'h0, obs_ov}, 32'h0);
        chk("reset_in_ready16", {31'h0, obs_ir}, 32'h1);
        beat(1, 0, 32'h0, 32'h0, 0, 0, 1);
        chk("reset_out_valid32", {31'h0, obs_ov}, 32'h0);
        chk("reset_sum32", obs_sum, 32'h0);

        // Directed vectors, latency checked
        lat_chk = 1;
        beat(0, 1, 32'h1234, 32'h0FED, 0, 0, 1); drain(0);
        chk("add_sum", last_sum, 32'h2221);
        chk("add_flags", {29'h0, last_cout, last_ovf, last_zero}, 32'h0);
        beat(0, 1, 32'h7FFF, 32'hFFFF, 1, 0, 1); drain(0);
        chk("subovf_sum", last_sum, 32'h8000);
        chk("subovf_flags", {29'h0, last_cout, last_ovf, last_zero}, 32'h2);
`ifdef CLA_PIPE_SAT_EN
        beat(0, 1, 32'h7FFF, 32'hFFFF, 1, 1, 1); drain(0);
        chk("sat_sum", last_sum, 32'h7FFF);
        chk("sat_ovf", {31'h0, last_ovf}, 32'h1);
`endif
        beat(0, 1, 32'h8000, 32'h8000, 0, 0, 1); drain(0);
        chk("zc_sum", last_sum, 32'h0);
        chk("zc_flags", {29'h0, last_cout, last_ovf, last_zero}, 32'h7);

        // Back-to-back throughput
        for (int i = 0; i < 5; i++)
            beat(0, 1, $urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1);
        drain(0);

        // Backpressure: out_ready low for cycles 3..5
        lat_chk = 0;
        base = n_out[0];
        sent = 0;
        ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
        for (int i = 0; i < 14; i++) begin
            beat(0, sent < 6, ra, rb, rs, 0, !(i >= 3 && i <= 5));
            if (i == 4) begin
                chk("bp_out_valid", {31'h0, obs_ov}, 32'h1);
                chk("bp_in_ready_low", {31'h0, obs_ir}, 32'h0);
            end
            if (sent < 6 && obs_ir) begin
                sent++;
                ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            end
        end
        drain(0);
        chk("bp_out_count", n_out[0] - base, 32'd6);

        // Reset with two beats in flight
        beat(0, 1, $urandom, $urandom, 0, 0, 1);
        beat(0, 1, $urandom, $urandom, 1, 0, 1);
        rst = 1'b1;
        beat(0, 0, 32'h0, 32'h0, 0, 0, 0);
        rst = 1'b0;
        q[0].delete();
        beat(0, 0, 32'h0, 32'h0, 0, 0, 1);
        chk("rst_out_valid", {31'h0, obs_ov}, 32'h0);
        chk("rst_sum", obs_sum, 32'h0);
        chk("rst_in_ready", {31'h0, obs_ir}, 32'h1);
        base = n_out[0];
        repeat (6) beat(0, 0, 32'h0, 32'h0, 0, 0, 1);
        chk("rst_no_stale", n_out[0] - base, 32'd0);

        // 32-bit / 4-stage build: latency then random sweep
        lat_chk = 1;
        beat(1, 1, $urandom, $urandom, 0, 0, 1); drain(1);
        beat(1, 1, $urandom, $urandom, 1, 0, 1); drain(1);
        lat_chk = 0;
        for (int i = 0; i < 1000; i++) begin
            riv   = 1'($urandom_range(0, 3) != 0);
            rordy = 1'($urandom_range(0, 3) != 0);
            rs    = 1'($urandom_range(0, 1));
`ifdef CLA_PIPE_SAT_EN
            rsat  = 1'($urandom_range(0, 1));
`else
            rsat  = 1'b0;
`endif
            beat(1, riv, $urandom, $urandom, rs, rsat, rordy);
        end
        drain(1);
        chk("sweep32_count", n_out[1], n_acc[1]);

        // 16-bit random traffic with random stalls
        for (int i = 0; i < 200; i++) begin
            riv   = 1'($urandom_range(0, 1));
            rordy = 1'($urandom_range(0, 1));
            beat(0, riv, $urandom, $urandom, 1'($urandom_range(0, 1)), 0, rordy);
        end
        drain(0);
        chk("sweep16_count", n_out[0], n_acc[0] - 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
